// File: rtl/model_algebra_pkg.sv
// Shared types, constants and arithmetic helpers for the algebra model blocks.
// Build option: define MODEL_ALGEBRA_DOT_PRODUCT_SATURATE_EN to make multiply and accumulate
// saturate to all-ones on overflow; otherwise both wrap modulo 2^width.
package model_algebra_pkg;

    localparam int unsigned DEFAULT_DATA_SIZE = 64;
    // Reserved control width, kept only so the algebra blocks share one definition.
    localparam int unsigned CONTROL_SIZE      = 4;
    // Helper functions operate on this container width; DATA_SIZE must not exceed it.
    localparam int unsigned MAX_DATA_SIZE     = 64;

    localparam logic [MAX_DATA_SIZE-1:0] ZERO_DATA = '0;
    localparam logic [MAX_DATA_SIZE-1:0] ONE_DATA  = 64'd1;

    typedef enum logic [1:0] {
        StIdle,
        StInput,
        StDrain,
        StEnder
    } dp_state_e;

    // All-ones value of the given width, right-aligned in the container.
    function automatic logic [MAX_DATA_SIZE-1:0] data_mask(input int unsigned width);
        if (width >= MAX_DATA_SIZE) return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

    // Product of two width-bit operands, reduced to width bits.
    function automatic logic [MAX_DATA_SIZE-1:0] mac_mul(input logic [MAX_DATA_SIZE-1:0] a,
                                                         input logic [MAX_DATA_SIZE-1:0] b,
                                                         input int unsigned width);
        logic [2*MAX_DATA_SIZE-1:0] prod;
        logic [MAX_DATA_SIZE-1:0]   mask;
        mask = data_mask(width);
        prod = {64'd0, a} * {64'd0, b};
`ifdef MODEL_ALGEBRA_DOT_PRODUCT_SATURATE_EN
        if (prod > {64'd0, mask}) return mask;
        return prod[MAX_DATA_SIZE-1:0];
`else
        return prod[MAX_DATA_SIZE-1:0] & mask;
`endif
    endfunction

    // Sum of two width-bit operands, reduced to width bits.
    function automatic logic [MAX_DATA_SIZE-1:0] mac_add(input logic [MAX_DATA_SIZE-1:0] a,
                                                         input logic [MAX_DATA_SIZE-1:0] b,
                                                         input int unsigned width);
        logic [MAX_DATA_SIZE:0]   sum;
        logic [MAX_DATA_SIZE-1:0] mask;
        mask = data_mask(width);
        sum  = {1'b0, a} + {1'b0, b};
`ifdef MODEL_ALGEBRA_DOT_PRODUCT_SATURATE_EN
        if (sum > {1'b0, mask}) return mask;
        return sum[MAX_DATA_SIZE-1:0];
`else
        return sum[MAX_DATA_SIZE-1:0] & mask;
`endif
    endfunction

endpackage

// File: rtl/model_algebra_dot_product_if.sv
// Element stream and result handshake between the algebra stimulus and the dot-product engine.
interface model_algebra_dot_product_if
    import model_algebra_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE
);
    logic                 dot_product_start;
    logic                 dot_product_ready;
    logic                 dot_product_data_a_in_enable;
    logic                 dot_product_data_b_in_enable;
    logic                 dot_product_data_out_enable;
    logic [DATA_SIZE-1:0] dot_product_length_in;
    logic [DATA_SIZE-1:0] dot_product_data_a_in;
    logic [DATA_SIZE-1:0] dot_product_data_b_in;
    logic [DATA_SIZE-1:0] dot_product_data_out;

    // Engine side.
    modport slave (
        input  dot_product_start,
        input  dot_product_data_a_in_enable,
        input  dot_product_data_b_in_enable,
        input  dot_product_length_in,
        input  dot_product_data_a_in,
        input  dot_product_data_b_in,
        output dot_product_ready,
        output dot_product_data_out_enable,
        output dot_product_data_out
    );

    // Stimulus side.
    modport master (
        output dot_product_start,
        output dot_product_data_a_in_enable,
        output dot_product_data_b_in_enable,
        output dot_product_length_in,
        output dot_product_data_a_in,
        output dot_product_data_b_in,
        input  dot_product_ready,
        input  dot_product_data_out_enable,
        input  dot_product_data_out
    );
endinterface

// File: rtl/model_algebra_mac_stage.sv
// Two-stage multiply-accumulate: product registered one edge after valid_i, accumulator one
// edge later. valid_o marks a staged product that the next edge folds into the accumulator.
module model_algebra_mac_stage
    import model_algebra_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic [DATA_SIZE-1:0] a_i,
    input  logic [DATA_SIZE-1:0] b_i,
    output logic [DATA_SIZE-1:0] acc_o,
    output logic                 valid_o
);
    logic [DATA_SIZE-1:0] prod_d, prod_q;
    logic [DATA_SIZE-1:0] acc_d, acc_q;
    logic                 prod_vld_d, prod_vld_q;

    // Next product / accumulator; clear discards any staged product.
    always_comb begin
        prod_d     = prod_q;
        prod_vld_d = valid_i;
        acc_d      = acc_q;
        if (valid_i) begin
            prod_d = DATA_SIZE'(mac_mul(MAX_DATA_SIZE'(a_i), MAX_DATA_SIZE'(b_i), DATA_SIZE));
        end
        if (prod_vld_q) begin
            acc_d = DATA_SIZE'(mac_add(MAX_DATA_SIZE'(acc_q), MAX_DATA_SIZE'(prod_q), DATA_SIZE));
        end
        if (clear_i) begin
            prod_vld_d = 1'b0;
            acc_d      = ZERO_DATA[DATA_SIZE-1:0];
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end

    assign acc_o   = acc_q;
    assign valid_o = prod_vld_q;
endmodule

// File: rtl/model_algebra_dot_product.sv
// Streaming dot-product engine: collects LENGTH (A,B) pairs, multiply-accumulates them and
// presents the scalar result with a one-cycle READY pulse.
// Build option: MODEL_ALGEBRA_DOT_PRODUCT_SATURATE_EN selects saturating arithmetic.
module model_algebra_dot_product
    import model_algebra_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input logic                        clk,
    input logic                        rst,
    model_algebra_dot_product_if.slave dp
);
    dp_state_e state_d, state_q;

    logic [DATA_SIZE-1:0] len_d, len_q, cnt_d, cnt_q, cnt_inc;
    logic [DATA_SIZE-1:0] a_d, a_q, b_d, b_q, pair_a_d, pair_a_q, pair_b_d, pair_b_q;
    logic [DATA_SIZE-1:0] data_out_d, data_out_q, acc;
    logic a_vld_d, a_vld_q, b_vld_d, b_vld_q, pair_vld_d, pair_vld_q;
    logic zero_wait_d, zero_wait_q, ready_d, ready_q, out_en_d, out_en_q;
    logic a_have, b_have, pair_form, last_pair, len_zero, mac_clear, mac_valid;

    // A fresh element pairs with a held one (or its partner) in the same edge.
    assign a_have    = a_vld_q | dp.dot_product_data_a_in_enable;
    assign b_have    = b_vld_q | dp.dot_product_data_b_in_enable;
    assign pair_form = (state_q == StInput) & a_have & b_have;
    assign cnt_inc   = cnt_q + ONE_DATA[DATA_SIZE-1:0];
    assign last_pair = (cnt_inc == len_q);
    assign len_zero  = (dp.dot_product_length_in == ZERO_DATA[DATA_SIZE-1:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (dp.dot_product_start) state_d = len_zero ? StEnder : StInput;
            StInput: if (pair_form && last_pair) state_d = StDrain;
            // Pair register empty and last product staged: accumulator settles this edge.
            StDrain: if (mac_valid && !pair_vld_q) state_d = StEnder;
            StEnder: if (!zero_wait_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output strobes.
    always_comb begin
        len_d       = len_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        a_vld_d     = a_vld_q;
        b_d         = b_q;
        b_vld_d     = b_vld_q;
        pair_a_d    = pair_a_q;
        pair_b_d    = pair_b_q;
        pair_vld_d  = 1'b0;
        zero_wait_d = zero_wait_q;
        ready_d     = 1'b0;
        out_en_d    = 1'b0;
        data_out_d  = data_out_q;
        mac_clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dp.dot_product_start) begin
                    len_d       = dp.dot_product_length_in;
                    cnt_d       = '0;
                    a_vld_d     = 1'b0;
                    b_vld_d     = 1'b0;
                    mac_clear   = 1'b1;
                    data_out_d  = '0;
                    zero_wait_d = len_zero;
                    out_en_d    = !len_zero;
                end
            end
            StInput: begin
                if (pair_form) begin
                    pair_vld_d = 1'b1;
                    pair_a_d   = a_vld_q ? a_q : dp.dot_product_data_a_in;
                    pair_b_d   = b_vld_q ? b_q : dp.dot_product_data_b_in;
                    cnt_d      = cnt_inc;
                    a_vld_d    = 1'b0;
                    b_vld_d    = 1'b0;
                    out_en_d   = !last_pair;
                end else begin
                    // Only the first arrival is held; repeats are dropped.
                    if (dp.dot_product_data_a_in_enable && !a_vld_q) begin
                        a_d     = dp.dot_product_data_a_in;
                        a_vld_d = 1'b1;
                    end
                    if (dp.dot_product_data_b_in_enable && !b_vld_q) begin
                        b_d     = dp.dot_product_data_b_in;
                        b_vld_d = 1'b1;
                    end
                end
            end
            StDrain: ;
            StEnder: begin
                // Zero-length runs spend one extra cycle here to keep READY timing fixed.
                if (zero_wait_q) begin
                    zero_wait_d = 1'b0;
                end else begin
                    ready_d    = 1'b1;
                    data_out_d = acc;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            a_vld_q     <= 1'b0;
            b_q         <= '0;
            b_vld_q     <= 1'b0;
            pair_a_q    <= '0;
            pair_b_q    <= '0;
            pair_vld_q  <= 1'b0;
            zero_wait_q <= 1'b0;
            ready_q     <= 1'b0;
            out_en_q    <= 1'b0;
            data_out_q  <= '0;
        end else begin
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            a_vld_q     <= a_vld_d;
            b_q         <= b_d;
            b_vld_q     <= b_vld_d;
            pair_a_q    <= pair_a_d;
            pair_b_q    <= pair_b_d;
            pair_vld_q  <= pair_vld_d;
            zero_wait_q <= zero_wait_d;
            ready_q     <= ready_d;
            out_en_q    <= out_en_d;
            data_out_q  <= data_out_d;
        end
    end

    model_algebra_mac_stage #(
        .DATA_SIZE (DATA_SIZE)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clear_i (mac_clear),
        .valid_i (pair_vld_q),
        .a_i     (pair_a_q),
        .b_i     (pair_b_q),
        .acc_o   (acc),
        .valid_o (mac_valid)
    );

    assign dp.dot_product_ready           = ready_q;
    assign dp.dot_product_data_out_enable = out_en_q;
    assign dp.dot_product_data_out        = data_out_q;
endmodule

// File: tb/tb_model_algebra_dot_product.sv
// Bench for the dot-product engine: directed cases plus randomized runs against a plain
// arithmetic reference, on a 64-bit instance and an 8-bit instance.
module tb_model_algebra_dot_product;
    import model_algebra_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    model_algebra_dot_product_if #(.DATA_SIZE(64)) bus ();
    model_algebra_dot_product_if #(.DATA_SIZE(8))  bus8 ();

    model_algebra_dot_product #(.DATA_SIZE(64)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (bus.slave)
    );

    model_algebra_dot_product #(.DATA_SIZE(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .dp  (bus8.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int ready_pulses, oen_pulses;
    bit overlap = 1'b0;
    logic [63:0] va [8];
    logic [63:0] vb [8];

    // Pulse bookkeeping for the 64-bit instance.
    always @(negedge clk) begin
        if (bus.dot_product_ready === 1'b1) ready_pulses++;
        if (bus.dot_product_data_out_enable === 1'b1) oen_pulses++;
        if (bus.dot_product_ready === 1'b1 && bus.dot_product_data_out_enable === 1'b1)
            overlap = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of pairwise products reduced to width bits.
    function automatic logic [63:0] ref_dot(input int len, input int width);
        logic [129:0] top, acc, p;
        top = (130'd1 << width) - 130'd1;
        acc = '0;
        for (int i = 0; i < len; i++) begin
            p = 130'(va[i]) * 130'(vb[i]);
`ifdef MODEL_ALGEBRA_DOT_PRODUCT_SATURATE_EN
            if (p > top) p = top;
            acc = acc + p;
            if (acc > top) acc = top;
`else
            acc = (acc + p) & top;
`endif
        end
        return acc[63:0];
    endfunction

    // Deliver pair i on the 64-bit bus. mode 0: coincident; 1: A leads B by 3 with a
    // duplicate A; 2: random order, duplicates and gaps. Returns at #1 after the pair edge.
    task automatic drive_pair(input int i, input int mode);
        bit a_first;
        int ndup, gap;
        if (mode == 0) begin
            bus.dot_product_data_a_in = va[i];
            bus.dot_product_data_b_in = vb[i];
            bus.dot_product_data_a_in_enable = 1'b1;
            bus.dot_product_data_b_in_enable = 1'b1;
            @(posedge clk); #1;
        end else begin
            a_first = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            ndup    = (mode == 1) ? 1 : int'($urandom_range(0, 2));
            gap     = (mode == 1) ? 1 : int'($urandom_range(0, 2));
            bus.dot_product_data_a_in = va[i];
            bus.dot_product_data_b_in = vb[i];
            bus.dot_product_data_a_in_enable = a_first;
            bus.dot_product_data_b_in_enable = !a_first;
            @(posedge clk); #1;
            for (int d = 0; d < ndup; d++) begin
                bus.dot_product_data_a_in = {$urandom, $urandom};
                bus.dot_product_data_b_in = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            bus.dot_product_data_a_in_enable = 1'b0;
            bus.dot_product_data_b_in_enable = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            bus.dot_product_data_a_in = va[i];
            bus.dot_product_data_b_in = vb[i];
            bus.dot_product_data_a_in_enable = !a_first;
            bus.dot_product_data_b_in_enable = a_first;
            @(posedge clk); #1;
        end
        bus.dot_product_data_a_in_enable = 1'b0;
        bus.dot_product_data_b_in_enable = 1'b0;
    endtask

    task automatic start64(input logic [63:0] len);
        @(negedge clk);
        bus.dot_product_length_in = len;
        bus.dot_product_start = 1'b1;
        @(posedge clk); #1;
        bus.dot_product_start = 1'b0;
    endtask

    // One complete run on the 64-bit instance using va/vb.
    task automatic run64(input string tag, input int len, input int mode, input bit restart);
        logic [63:0] exp;
        int k;
        exp = ref_dot(len, 64);
        ready_pulses = 0;
        oen_pulses   = 0;
        start64(64'(len));
        if (len == 0) begin
            check({tag, " ready@1"}, 64'(bus.dot_product_ready), 64'd0);
            @(posedge clk); #1;
            check({tag, " ready@2"}, 64'(bus.dot_product_ready), 64'd0);
            @(posedge clk); #1;
            check({tag, " ready@3"}, 64'(bus.dot_product_ready), 64'd1);
            check({tag, " data"}, bus.dot_product_data_out, 64'd0);
        end else begin
            for (int i = 0; i < len; i++) begin
                drive_pair(i, mode);
                if (i < len - 1)
                    check({tag, " oen"}, 64'(bus.dot_product_data_out_enable), 64'd1);
                if (i == 0 && restart) begin
                    bus.dot_product_length_in = 64'd9;
                    bus.dot_product_start = 1'b1;
                    @(posedge clk); #1;
                    bus.dot_product_start = 1'b0;
                end
            end
            k = 0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (bus.dot_product_ready === 1'b1) begin k = c; break; end
            end
            check({tag, " latency"}, 64'(k), 64'd3);
            check({tag, " data"}, bus.dot_product_data_out, exp);
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, " ready pulses"}, 64'(ready_pulses), 64'd1);
        check({tag, " oen pulses"}, 64'(oen_pulses), 64'(len));
    endtask

    // One coincident-enable run on the 8-bit instance using va/vb.
    task automatic run8(input string tag, input int len);
        logic [63:0] exp;
        int k;
        exp = ref_dot(len, 8);
        @(negedge clk);
        bus8.dot_product_length_in = 8'(len);
        bus8.dot_product_start = 1'b1;
        @(posedge clk); #1;
        bus8.dot_product_start = 1'b0;
        for (int i = 0; i < len; i++) begin
            bus8.dot_product_data_a_in = 8'(va[i]);
            bus8.dot_product_data_b_in = 8'(vb[i]);
            bus8.dot_product_data_a_in_enable = 1'b1;
            bus8.dot_product_data_b_in_enable = 1'b1;
            @(posedge clk); #1;
            bus8.dot_product_data_a_in_enable = 1'b0;
            bus8.dot_product_data_b_in_enable = 1'b0;
        end
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus8.dot_product_ready === 1'b1) begin k = c; break; end
        end
        check({tag, " latency"}, 64'(k), 64'd3);
        check({tag, " data"}, 64'(bus8.dot_product_data_out), exp);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bus.dot_product_start = 1'b0;
        bus.dot_product_data_a_in_enable = 1'b0;
        bus.dot_product_data_b_in_enable = 1'b0;
        bus.dot_product_length_in = '0;
        bus.dot_product_data_a_in = '0;
        bus.dot_product_data_b_in = '0;
        bus8.dot_product_start = 1'b0;
        bus8.dot_product_data_a_in_enable = 1'b0;
        bus8.dot_product_data_b_in_enable = 1'b0;
        bus8.dot_product_length_in = '0;
        bus8.dot_product_data_a_in = '0;
        bus8.dot_product_data_b_in = '0;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset ready", 64'(bus.dot_product_ready), 64'd0);
        check("reset oen", 64'(bus.dot_product_data_out_enable), 64'd0);
        check("reset data", bus.dot_product_data_out, 64'd0);

        // Basic run, coincident enables.
        va[0] = 1; va[1] = 2; va[2] = 3;
        vb[0] = 4; vb[1] = 5; vb[2] = 6;
        run64("t1", 3, 0, 1'b0);
        check("t1 model", ref_dot(3, 64), 64'd32);

        // Zero length.
        run64("t2", 0, 0, 1'b0);

        // A leads B with a dropped duplicate A.
        va[0] = 64'd11; vb[0] = 64'd13; va[1] = 64'd17; vb[1] = 64'd19;
        run64("t3", 2, 1, 1'b0);

        // Overflow on the 8-bit instance.
        va[0] = 16; vb[0] = 16;
        run8("t4 mul", 1);
        va[0] = 15; vb[0] = 17; va[1] = 1; vb[1] = 1;
        run8("t4 acc", 2);

        // Reset part-way through a run.
        va[0] = 5; vb[0] = 9;
        ready_pulses = 0;
        start64(64'd4);
        drive_pair(0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5 ready", 64'(bus.dot_product_ready), 64'd0);
        check("t5 oen", 64'(bus.dot_product_data_out_enable), 64'd0);
        check("t5 data", bus.dot_product_data_out, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("t5 no ready", 64'(ready_pulses), 64'd0);
        va[0] = 7; vb[0] = 3;
        run64("t5 rerun", 1, 0, 1'b0);

        // START re-asserted mid-run is ignored.
        va[0] = 1; va[1] = 2; va[2] = 3;
        vb[0] = 4; vb[1] = 5; vb[2] = 6;
        run64("t6", 3, 0, 1'b1);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                if (r < 4) begin
                    va[i] = 64'($urandom_range(0, 1000));
                    vb[i] = 64'($urandom_range(0, 1000));
                end else begin
                    va[i] = {$urandom, $urandom};
                    vb[i] = {$urandom, $urandom};
                end
            end
            run64($sformatf("rand%0d", r), len, 2, 1'b0);
        end

        check("ready/oen overlap", 64'(overlap), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
